// File: rtl/seg7_display_arbiter.sv
// Round-robin owner of the shared 4-digit 7-seg display; each accepted value
// is held for HOLD_CYCLES before the next requester can take over.
module seg7_display_arbiter #(
  parameter  int NUM_REQ     = 3,
  parameter  int HOLD_CYCLES = 27_000_000,
  localparam int IDX_W       = $clog2(NUM_REQ)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [16*NUM_REQ-1:0]  req_data_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  input  logic                   test_i,
  output logic [15:0]            hex_o,
  output logic                   test_o,
  output logic [IDX_W-1:0]       owner_o,
  output logic                   busy_o
);

  localparam int               TIMER_W   = $clog2(HOLD_CYCLES + 1);
  localparam logic [TIMER_W-1:0] HOLD_LOAD = TIMER_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [15:0]          hex_q, hex_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic                 busy_q, busy_d;
  logic                 test_q, test_d;

  logic [IDX_W-1:0]     grant;
  logic                 found;
  logic                 accept;
  logic [15:0]          grant_data;
  int                   idx;

  // Rotating search starting at the pointer: first valid requester wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid_i[IDX_W'(idx)]) begin
        found = 1'b1;
        grant = IDX_W'(idx);
      end
    end
  end

  assign accept = (state_q == IDLE) && found;

  always_comb begin
    grant_data  = '0;
    req_ready_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant == IDX_W'(i)) grant_data = req_data_i[16*i +: 16];
      req_ready_o[i] = accept && !rst_i && (grant == IDX_W'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    timer_d = timer_q;
    hex_d   = hex_q;
    owner_d = owner_q;
    busy_d  = busy_q;
    test_d  = test_i;
    case (state_q)
      IDLE: begin
        if (accept) begin
          hex_d   = grant_data;
          owner_d = grant;
          ptr_d   = (grant == LAST_IDX) ? '0 : grant + IDX_W'(1);
          timer_d = HOLD_LOAD;
          busy_d  = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // Timer holds the number of HOLD cycles still to come after this one.
        if (timer_q == '0) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      timer_q <= '0;
      hex_q   <= '0;
      owner_q <= '0;
      busy_q  <= 1'b0;
      test_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      timer_q <= timer_d;
      hex_q   <= hex_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
      test_q  <= test_d;
    end
  end

  assign hex_o   = hex_q;
  assign owner_o = owner_q;
  assign busy_o  = busy_q;
  assign test_o  = test_q;

endmodule

// File: tb/tb_seg7_display_arbiter.sv
// Bench for seg7_display_arbiter: transaction-level model of round-robin
// grants with fixed hold windows, plus a HOLD_CYCLES=1 instance.
module tb_seg7_display_arbiter;

  localparam int N = 3;
  localparam int H = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req_valid = '0;
  logic [47:0] req_data = '0;
  logic [2:0]  ready;
  logic        test_i = 1'b0;
  logic [15:0] hex;
  logic        test_o;
  logic [1:0]  owner;
  logic        busy;

  logic        rst2 = 1'b1;
  logic [2:0]  valid2 = '0;
  logic [47:0] data2 = '0;
  logic [2:0]  ready2;
  logic        test2_i = 1'b0;
  logic [15:0] hex2;
  logic        test2_o;
  logic [1:0]  owner2;
  logic        busy2;

  int checks = 0;
  int failures = 0;

  // Model: pointer, last shown value/owner, and cycle of the last accept.
  int          m_ptr, m_owner, m_last, cyc;
  logic [15:0] m_hex;
  logic        m_test;
  logic [2:0]  last_ready;

  always #5 clk = ~clk;

  seg7_display_arbiter #(.NUM_REQ(N), .HOLD_CYCLES(H)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_data_i(req_data),
    .req_ready_o(ready), .test_i(test_i), .hex_o(hex), .test_o(test_o),
    .owner_o(owner), .busy_o(busy)
  );

  seg7_display_arbiter #(.NUM_REQ(N), .HOLD_CYCLES(1)) dut1 (
    .clk_i(clk), .rst_i(rst2), .req_valid_i(valid2), .req_data_i(data2),
    .req_ready_o(ready2), .test_i(test2_i), .hex_o(hex2), .test_o(test2_o),
    .owner_o(owner2), .busy_o(busy2)
  );

  task automatic model_reset();
    m_ptr = 0; m_owner = 0; m_last = -100; cyc = 0; m_hex = '0; m_test = 1'b0;
  endtask

  function automatic logic [2:0] model_ready(input logic [2:0] v);
    int idx;
    if (cyc <= m_last + H) return 3'b000;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (v[idx]) return 3'(1 << idx);
    end
    return 3'b000;
  endfunction

  // One clock of stimulus; checks ready before the edge and outputs after it.
  task automatic do_cycle(input logic [2:0] v, input logic [47:0] d, input logic t);
    logic [2:0] er;
    logic       eb;
    req_valid = v; req_data = d; test_i = t;
    #1;
    er = model_ready(v);
    last_ready = ready;
    checks++;
    if (ready !== er) begin
      failures++; $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, ready, er);
    end
    @(posedge clk);
    if (er != 3'b000) begin
      for (int g = 0; g < N; g++) if (er[g]) begin
        m_hex = d[16*g +: 16]; m_owner = g; m_ptr = (g + 1) % N; m_last = cyc;
      end
    end
    m_test = t;
    cyc++;
    #1;
    eb = (cyc <= m_last + H);
    checks += 4;
    if (hex !== m_hex) begin
      failures++; $display("FAIL hex cyc=%0d got=%h exp=%h", cyc, hex, m_hex);
    end
    if (owner !== 2'(m_owner)) begin
      failures++; $display("FAIL owner cyc=%0d got=%0d exp=%0d", cyc, owner, m_owner);
    end
    if (busy !== eb) begin
      failures++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, eb);
    end
    if (test_o !== m_test) begin
      failures++; $display("FAIL test_o cyc=%0d got=%b exp=%b", cyc, test_o, m_test);
    end
  endtask

  task automatic idle_out();
    for (int i = 0; i < H + 1; i++) do_cycle(3'b000, 48'h0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = 3'b111;
    #1;
    checks += 4;
    if (ready !== 3'b000) begin failures++; $display("FAIL rst_ready got=%b exp=000", ready); end
    if (hex !== 16'h0)    begin failures++; $display("FAIL rst_hex got=%h exp=0000", hex); end
    if (busy !== 1'b0)    begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    if (test_o !== 1'b0)  begin failures++; $display("FAIL rst_test got=%b exp=0", test_o); end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    req_valid = 3'b111; req_data = {16'h3333, 16'h2222, 16'h1111};
    #1;
    checks++;
    if (ready !== 3'b001) begin failures++; $display("FAIL first_ready got=%b exp=001", ready); end
    do_cycle(3'b111, {16'h3333, 16'h2222, 16'h1111}, 1'b0);
    idle_out();
  endtask

  task automatic test_single();
    logic [4:0] bseq;
    do_cycle(3'b010, {16'h0, 16'hBEEF, 16'h0}, 1'b0);
    checks += 2;
    if (last_ready !== 3'b010) begin failures++; $display("FAIL single_ready got=%b exp=010", last_ready); end
    if (hex !== 16'hBEEF) begin failures++; $display("FAIL single_hex got=%h exp=beef", hex); end
    bseq[0] = busy;
    for (int i = 1; i < 5; i++) begin
      do_cycle(3'b000, 48'h0, 1'b0);
      bseq[i] = busy;
    end
    checks++;
    if (bseq !== 5'b01111) begin failures++; $display("FAIL single_busy_seq got=%b exp=01111", bseq); end
  endtask

  task automatic test_round_robin();
    int          acc_c[$];
    logic [15:0] acc_h[$];
    int          exp_c[4] = '{0, 5, 10, 15};
    logic [15:0] exp_h[4] = '{16'h1111, 16'h2222, 16'h3333, 16'h1111};
    do_reset();
    for (int c = 0; c < 20; c++) begin
      do_cycle(3'b111, {16'h3333, 16'h2222, 16'h1111}, 1'b0);
      if (last_ready != 3'b000) begin acc_c.push_back(c); acc_h.push_back(hex); end
    end
    checks++;
    if (acc_c.size() != 4) begin
      failures++; $display("FAIL rr_count got=%0d exp=4", acc_c.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks += 2;
        if (acc_c[i] != exp_c[i]) begin failures++; $display("FAIL rr_cycle%0d got=%0d exp=%0d", i, acc_c[i], exp_c[i]); end
        if (acc_h[i] !== exp_h[i]) begin failures++; $display("FAIL rr_hex%0d got=%h exp=%h", i, acc_h[i], exp_h[i]); end
      end
    end
    idle_out();
  endtask

  task automatic test_wrap();
    logic [2:0] grants[$];
    do_cycle(3'b010, {16'h0, 16'h2222, 16'h0}, 1'b0);
    for (int c = 0; c < 11; c++) begin
      do_cycle(3'b101, {16'hCCCC, 16'h0, 16'hAAAA}, 1'b0);
      if (last_ready != 3'b000) grants.push_back(last_ready);
    end
    checks++;
    if (grants.size() != 2 || grants[0] !== 3'b100 || grants[1] !== 3'b001) begin
      failures++; $display("FAIL wrap_order n=%0d exp 100 then 001", grants.size());
    end
    idle_out();
  endtask

  task automatic test_hold_block();
    int n_rdy = 0;
    do_cycle(3'b001, {16'h0, 16'h0, 16'h5A5A}, 1'b0);
    do_cycle(3'b000, 48'h0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      do_cycle(3'b100, {16'h7777, 16'h0, 16'h0}, 1'b0);
      if (last_ready != 3'b000) n_rdy++;
    end
    for (int i = 0; i < 6; i++) begin
      do_cycle(3'b000, 48'h0, 1'b0);
      if (last_ready != 3'b000) n_rdy++;
    end
    checks += 2;
    if (n_rdy != 0) begin failures++; $display("FAIL block_ready got=%0d exp=0", n_rdy); end
    if (hex !== 16'h5A5A) begin failures++; $display("FAIL block_hex got=%h exp=5a5a", hex); end
  endtask

  task automatic test_lamp_and_mid_reset();
    do_cycle(3'b010, {16'h0, 16'h1234, 16'h0}, 1'b0);
    do_cycle(3'b000, 48'h0, 1'b1);
    checks += 2;
    if (test_o !== 1'b1) begin failures++; $display("FAIL lamp_test got=%b exp=1", test_o); end
    if (busy !== 1'b1)   begin failures++; $display("FAIL lamp_busy got=%b exp=1", busy); end
    req_valid = 3'b111; test_i = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks += 4;
    if (hex !== 16'h0)    begin failures++; $display("FAIL midrst_hex got=%h exp=0000", hex); end
    if (busy !== 1'b0)    begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    if (owner !== 2'd0)   begin failures++; $display("FAIL midrst_owner got=%0d exp=0", owner); end
    if (ready !== 3'b000) begin failures++; $display("FAIL midrst_ready got=%b exp=000", ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    do_cycle(3'b111, {16'h3333, 16'h2222, 16'h1111}, 1'b0);
    idle_out();
  endtask

  task automatic test_random();
    logic [47:0] d;
    for (int i = 0; i < 300; i++) begin
      d = {16'($urandom), 16'($urandom), 16'($urandom)};
      do_cycle(3'($urandom), d, 1'($urandom));
    end
  endtask

  task automatic test_hold1();
    logic [2:0]  er;
    logic [15:0] eh;
    valid2 = 3'b111; data2 = {16'hC003, 16'hB002, 16'hA001};
    @(posedge clk); #1;
    rst2 = 1'b0;
    for (int c = 0; c < 12; c++) begin
      #1;
      er = (c % 2 == 0) ? 3'(1 << ((c / 2) % N)) : 3'b000;
      checks++;
      if (ready2 !== er) begin failures++; $display("FAIL h1_ready c=%0d got=%b exp=%b", c, ready2, er); end
      @(posedge clk); #1;
      if (c % 2 == 0) begin
        eh = data2[16*((c / 2) % N) +: 16];
        checks += 2;
        if (hex2 !== eh)    begin failures++; $display("FAIL h1_hex c=%0d got=%h exp=%h", c, hex2, eh); end
        if (busy2 !== 1'b1) begin failures++; $display("FAIL h1_busy c=%0d got=%b exp=1", c, busy2); end
      end
    end
  endtask

  initial begin
    model_reset();
    last_ready = '0;
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_hold_block();
    test_lamp_and_mid_reset();
    test_random();
    test_hold1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
